score_bcd_counter: RTL and testbench

SCORE_BCD_COUNTER -- requirements
Module: score_bcd_counter

---
 rtl/score_pkg.sv | 20 ++
 rtl/bcd_digit_add.sv | 19 +
 rtl/score_bcd_counter.sv | 169 ++++++++++++++++
 tb/tb_score_bcd_counter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score counter.
package score_pkg;

  // Digit-serial adder control: IDLE waits for work, ADD ripples one digit per cycle.
  typedef enum logic {
    IDLE = 1'b0,
    ADD  = 1'b1
  } state_e;

  // Display code that the seven-segment decoders render as an unlit digit.
  localparam logic [3:0] BCD_BLANK  = 4'hF;
  localparam int         MAX_DIGITS = 6;
  localparam int         IDX_W      = $clog2(MAX_DIGITS);

  // Out-of-range BCD input is treated as the largest legal digit.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder: digit + addend + carry_in, decimal-corrected.
module bcd_digit_add (
  input  logic [3:0] digit,
  input  logic [3:0] addend,
  input  logic       carry_in,
  output logic [3:0] digit_out,
  output logic       carry_out
);

  logic [4:0] sum;

  // Binary sum of the operands, then subtract ten when it leaves the decimal range.
  always_comb begin
    sum       = {1'b0, digit} + {1'b0, addend} + {4'b0000, carry_in};
    carry_out = (sum >= 5'd10);
    digit_out = carry_out ? 4'(sum - 5'd10) : sum[3:0];
  end

endmodule

// File: rtl/score_bcd_counter.sv
// Game score counter: digit-serial BCD accumulate, saturation, high-score
// tracking and leading-zero-blanked display codes.
module score_bcd_counter
  import score_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int BLANK_LEADING = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                add_valid,
  input  logic [3:0]          add_value,
  output logic                add_ready,
  input  logic                clear,
  input  logic                game_over,
  input  logic                show_high,
  output logic [4*DIGITS-1:0] disp_digits,
  output logic                new_high,
  output logic                saturated
);

  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  state_e              state_q,     state_d;
  logic [IDX_W-1:0]    idx_q,       idx_d;
  logic                carry_q,     carry_d;
  logic [3:0]          addend_q,    addend_d;
  logic [4*DIGITS-1:0] score_q,     score_d;
  logic [4*DIGITS-1:0] high_q,      high_d;
  logic                pending_q,   pending_d;
  logic                new_high_q,  new_high_d;
  logic                saturated_q, saturated_d;

  logic [3:0]          cur_digit;
  logic [3:0]          cur_addend;
  logic [3:0]          sum_digit;
  logic                sum_carry;
  logic                add_accept;

  logic [4*DIGITS-1:0] disp_src;
  logic                leading;

  assign add_ready  = (state_q == IDLE) && !clear;
  assign add_accept = add_valid && add_ready;
  assign new_high   = new_high_q;
  assign saturated  = saturated_q;

  // Select the score digit addressed by the ripple index; the addend only enters at digit 0.
  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) cur_digit = score_q[4*i +: 4];
    end
    cur_addend = (idx_q == '0) ? addend_q : 4'd0;
  end

  // One adder shared by every digit position.
  bcd_digit_add u_digit_add (
    .digit     (cur_digit),
    .addend    (cur_addend),
    .carry_in  (carry_q),
    .digit_out (sum_digit),
    .carry_out (sum_carry)
  );

  // Next-state logic: clear wins, then high-score commit and add acceptance in IDLE, ripple in ADD.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    addend_d    = addend_q;
    score_d     = score_q;
    high_d      = high_q;
    pending_d   = pending_q;
    new_high_d  = 1'b0;
    saturated_d = saturated_q;

    if (clear) begin
      state_d     = IDLE;
      idx_d       = '0;
      carry_d     = 1'b0;
      score_d     = '0;
      pending_d   = 1'b0;
      saturated_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Valid BCD nibbles order like plain binary, so a vector compare is a decimal compare.
          if (game_over || pending_q) begin
            pending_d = 1'b0;
            if (score_q > high_q) begin
              high_d     = score_q;
              new_high_d = 1'b1;
            end
          end
          // A saturated score absorbs further points without starting a ripple.
          if (add_accept && !saturated_q) begin
            state_d  = ADD;
            idx_d    = '0;
            carry_d  = 1'b0;
            addend_d = clamp_bcd(add_value);
          end
        end
        ADD: begin
          if (game_over) pending_d = 1'b1;
          if (sum_carry && (idx_q == LAST_IDX)) begin
            score_d     = ALL_NINES;
            saturated_d = 1'b1;
            state_d     = IDLE;
          end else begin
            for (int i = 0; i < DIGITS; i++) begin
              if (idx_q == IDX_W'(i)) score_d[4*i +: 4] = sum_digit;
            end
            if (sum_carry) begin
              idx_d   = idx_q + IDX_W'(1);
              carry_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers; reset abandons any ripple in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      addend_q    <= 4'd0;
      score_q     <= '0;
      high_q      <= '0;
      pending_q   <= 1'b0;
      new_high_q  <= 1'b0;
      saturated_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      addend_q    <= addend_d;
      score_q     <= score_d;
      high_q      <= high_d;
      pending_q   <= pending_d;
      new_high_q  <= new_high_d;
      saturated_q <= saturated_d;
    end
  end

  // Display path: pick score or high score, blank zeros above the top non-zero digit.
  always_comb begin
    disp_src    = show_high ? high_q : score_q;
    disp_digits = disp_src;
    leading     = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if ((BLANK_LEADING != 0) && leading && (disp_src[4*i +: 4] == 4'd0)) begin
        disp_digits[4*i +: 4] = BCD_BLANK;
      end else begin
        leading = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_score_bcd_counter.sv
// Directed self-checking bench for score_bcd_counter (DIGITS = 4, blanking on).
module tb_score_bcd_counter;

  logic        clk;
  logic        rst_n;
  logic        add_valid;
  logic [3:0]  add_value;
  logic        add_ready;
  logic        clear;
  logic        game_over;
  logic        show_high;
  logic [15:0] disp_digits;
  logic        new_high;
  logic        saturated;

  int tests_run;
  int tests_failed;

  score_bcd_counter #(.DIGITS(4), .BLANK_LEADING(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .add_valid   (add_valid),
    .add_value   (add_value),
    .add_ready   (add_ready),
    .clear       (clear),
    .game_over   (game_over),
    .show_high   (show_high),
    .disp_digits (disp_digits),
    .new_high    (new_high),
    .saturated   (saturated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one add for a single edge (accepted when add_ready is high).
  task automatic pulse_add(input logic [3:0] v);
    add_valid = 1'b1;
    add_value = v;
    tick();
    add_valid = 1'b0;
    add_value = 4'd0;
  endtask

  // Add one value and wait, with a cycle budget, for the counter to go idle again.
  task automatic add_wait(input logic [3:0] v);
    int n;
    pulse_add(v);
    n = 0;
    while (!add_ready && n < 10) begin
      tick();
      n++;
    end
    tests_run++;
    if (!add_ready) begin
      tests_failed++;
      $display("FAIL add_wait_timeout: add_ready=%b after %0d cycles, expected 1", add_ready, n);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic pulse_game_over();
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
  endtask

  // Clear, then reach the target with adds of 9 and one remainder add.
  task automatic build_score(input int target);
    pulse_clear();
    for (int k = 0; k < target / 9; k++) add_wait(4'd9);
    if (target % 9 != 0) add_wait(4'(target % 9));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests_run++;
    if (add_ready !== 1'b1 || new_high !== 1'b0 || saturated !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: ready=%b new_high=%b sat=%b, expected 1 0 0", add_ready, new_high, saturated);
    end
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (disp_digits !== 16'hFFF0) begin
      tests_failed++;
      $display("FAIL reset_disp: got %h, expected fff0", disp_digits);
    end
    show_high = 1'b1;
    #1;
    tests_run++;
    if (disp_digits !== 16'hFFF0) begin
      tests_failed++;
      $display("FAIL reset_high_disp: got %h, expected fff0", disp_digits);
    end
    show_high = 1'b0;
  endtask

  task automatic test_add_7_5();
    pulse_clear();
    add_wait(4'd7);
    tests_run++;
    if (disp_digits !== 16'hFFF7) begin
      tests_failed++;
      $display("FAIL add7: got %h, expected fff7", disp_digits);
    end
    pulse_add(4'd5);
    tests_run++;
    if (add_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL add5_busy: ready=%b, expected 0", add_ready);
    end
    tick();
    tests_run++;
    if (add_ready !== 1'b0 || disp_digits !== 16'hFFF2) begin
      tests_failed++;
      $display("FAIL add5_cycle1: ready=%b disp=%h, expected 0 fff2", add_ready, disp_digits);
    end
    tick();
    tests_run++;
    if (add_ready !== 1'b1 || disp_digits !== 16'hFF12) begin
      tests_failed++;
      $display("FAIL add5_done: ready=%b disp=%h, expected 1 ff12", add_ready, disp_digits);
    end
  endtask

  task automatic test_ripple();
    build_score(999);
    tests_run++;
    if (disp_digits !== 16'hF999) begin
      tests_failed++;
      $display("FAIL build999: got %h, expected f999", disp_digits);
    end
    pulse_add(4'd1);
    for (int c = 1; c <= 3; c++) begin
      tick();
      tests_run++;
      if (add_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL ripple_busy: cycle %0d ready=%b, expected 0", c, add_ready);
      end
    end
    tick();
    tests_run++;
    if (add_ready !== 1'b1 || disp_digits !== 16'h1000) begin
      tests_failed++;
      $display("FAIL ripple_done: ready=%b disp=%h, expected 1 1000", add_ready, disp_digits);
    end
  endtask

  task automatic test_saturate();
    build_score(9995);
    add_wait(4'd9);
    tests_run++;
    if (disp_digits !== 16'h9999 || saturated !== 1'b1) begin
      tests_failed++;
      $display("FAIL saturate: disp=%h sat=%b, expected 9999 1", disp_digits, saturated);
    end
    add_wait(4'd3);
    tests_run++;
    if (disp_digits !== 16'h9999 || saturated !== 1'b1) begin
      tests_failed++;
      $display("FAIL saturate_hold: disp=%h sat=%b, expected 9999 1", disp_digits, saturated);
    end
    pulse_clear();
    tests_run++;
    if (disp_digits !== 16'hFFF0 || saturated !== 1'b0) begin
      tests_failed++;
      $display("FAIL saturate_clear: disp=%h sat=%b, expected fff0 0", disp_digits, saturated);
    end
  endtask

  task automatic test_high_score();
    build_score(42);
    pulse_game_over();
    tests_run++;
    if (new_high !== 1'b1) begin
      tests_failed++;
      $display("FAIL new_high_pulse: got %b, expected 1", new_high);
    end
    tick();
    tests_run++;
    if (new_high !== 1'b0) begin
      tests_failed++;
      $display("FAIL new_high_once: got %b, expected 0", new_high);
    end
    pulse_clear();
    add_wait(4'd9);
    pulse_game_over();
    tests_run++;
    if (new_high !== 1'b0) begin
      tests_failed++;
      $display("FAIL no_new_high: got %b, expected 0", new_high);
    end
    show_high = 1'b1;
    #1;
    tests_run++;
    if (disp_digits !== 16'hFF42) begin
      tests_failed++;
      $display("FAIL high_disp: got %h, expected ff42", disp_digits);
    end
    show_high = 1'b0;
    #1;
    tests_run++;
    if (disp_digits !== 16'hFFF9) begin
      tests_failed++;
      $display("FAIL score_disp: got %h, expected fff9", disp_digits);
    end
  endtask

  task automatic test_pending_and_clear();
    build_score(999);
    pulse_add(4'd1);
    pulse_game_over();
    for (int c = 2; c <= 4; c++) begin
      tick();
      tests_run++;
      if (new_high !== 1'b0) begin
        tests_failed++;
        $display("FAIL pending_early: cycle %0d new_high=%b, expected 0", c, new_high);
      end
    end
    tests_run++;
    if (disp_digits !== 16'h1000 || add_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL pending_sum: disp=%h ready=%b, expected 1000 1", disp_digits, add_ready);
    end
    tick();
    tests_run++;
    if (new_high !== 1'b1) begin
      tests_failed++;
      $display("FAIL pending_commit: new_high=%b, expected 1", new_high);
    end
    show_high = 1'b1;
    #1;
    tests_run++;
    if (disp_digits !== 16'h1000) begin
      tests_failed++;
      $display("FAIL pending_high: got %h, expected 1000", disp_digits);
    end
    show_high = 1'b0;
    pulse_add(4'd9);
    clear = 1'b1;
    #1;
    tests_run++;
    if (add_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_blocks_ready: got %b, expected 0", add_ready);
    end
    tick();
    clear = 1'b0;
    #1;
    tests_run++;
    if (disp_digits !== 16'hFFF0 || add_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_mid_add: disp=%h ready=%b, expected fff0 1", disp_digits, add_ready);
    end
    tick();
    tests_run++;
    if (disp_digits !== 16'hFFF0) begin
      tests_failed++;
      $display("FAIL clear_abort: got %h, expected fff0", disp_digits);
    end
  endtask

  task automatic test_clamp_and_reset();
    pulse_clear();
    add_wait(4'hC);
    tests_run++;
    if (disp_digits !== 16'hFFF9) begin
      tests_failed++;
      $display("FAIL clamp: got %h, expected fff9", disp_digits);
    end
    build_score(999);
    pulse_add(4'd1);
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    tests_run++;
    if (disp_digits !== 16'hFFF0 || add_ready !== 1'b1 || new_high !== 1'b0 || saturated !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_add: disp=%h ready=%b nh=%b sat=%b, expected fff0 1 0 0",
               disp_digits, add_ready, new_high, saturated);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tests_run++;
    if (disp_digits !== 16'hFFF0 || add_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_no_partial: disp=%h ready=%b, expected fff0 1", disp_digits, add_ready);
    end
    show_high = 1'b1;
    #1;
    tests_run++;
    if (disp_digits !== 16'hFFF0) begin
      tests_failed++;
      $display("FAIL reset_high_cleared: got %h, expected fff0", disp_digits);
    end
    show_high = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    add_valid    = 1'b0;
    add_value    = 4'd0;
    clear        = 1'b0;
    game_over    = 1'b0;
    show_high    = 1'b0;

    test_reset();
    test_add_7_5();
    test_ripple();
    test_saturate();
    test_high_score();
    test_pending_and_clear();
    test_clamp_and_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
